// File: rtl/mux16_rr_scheduler_if.sv
// rtl/mux16_rr_scheduler_if.sv - request/grant/beat bundle between requesters, scheduler and downstream
interface mux16_rr_scheduler_if;
    logic [15:0] req;
    logic        rdy;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        vld;
    logic        last;

    modport slave  (input  req, rdy, output sel, gnt, vld, last);
    modport master (output req, rdy, input  sel, gnt, vld, last);
endinterface

// File: rtl/mux16_rr_scheduler.sv
// rtl/mux16_rr_scheduler.sv - round-robin select/grant scheduler for a shared 16:1 mux, bursts of up to BURST_MAX beats
// Optional MUX16_SCHED_PRIO0_EN: requester 0 wins every IDLE arbitration it takes part in.
module mux16_rr_scheduler #(
    parameter int BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux16_rr_scheduler_if.slave   bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] gnt_q, gnt_d;

    logic [3:0]  win;
    logic [3:0]  scan_idx;
    logic        found;
    logic        vld;
    logic        last;
    logic        beat;

    // First set request scanning upward from ptr, wrapping modulo 16.
    always_comb begin
        win      = ptr_q;
        found    = 1'b0;
        scan_idx = ptr_q;
        for (int i = 0; i < 16; i++) begin
            scan_idx = ptr_q + 4'(i);
            if (!found && bus.req[scan_idx]) begin
                win   = scan_idx;
                found = 1'b1;
            end
        end
`ifdef MUX16_SCHED_PRIO0_EN
        if (bus.req[0]) begin
            win = 4'd0;
        end
`endif
    end

    always_comb begin
        vld  = (state_q == GRANT) && bus.req[sel_q];
        last = vld && (cnt_q == 4'(BURST_MAX - 1));
        beat = vld && bus.rdy;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|bus.req) begin
                    sel_d   = win;
                    gnt_d   = 16'(1) << win;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Withdrawal and final beat both release; sel is held so the mux stays put.
                if (!bus.req[sel_q] || (beat && last)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + 4'd1;
                end else if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.gnt  = gnt_q;
    assign bus.vld  = vld;
    assign bus.last = last;

endmodule
